// File: rtl/test_run_sequencer_pkg.sv
// Shared types and widths for the test-run sequencer.
package test_run_sequencer_pkg;

   localparam int unsigned RUN_COUNT_WIDTH = 16;
   localparam int unsigned LATENCY_WIDTH   = 32;

   typedef enum logic [3:0] {
      StIdle,
      StDutReset,
      StWaitStartup,
      StConfig,
      StIssue,
      StWaitResult,
      StPop,
      StDone,
      StTimeout
   } state_t;

   function automatic logic [LATENCY_WIDTH-1:0] sat_inc(input logic [LATENCY_WIDTH-1:0] v);
      return (&v) ? v : v + LATENCY_WIDTH'(1);
   endfunction

endpackage

// File: rtl/test_run_sequencer_if.sv
// Runner-facing signals: reset, startup, run-call handshake, result pop and stall-rate config.
interface test_run_sequencer_if #(
   parameter int unsigned STALL_RATE_WIDTH = 8
);
   logic                        dut_rst_out;
   logic                        dut_startup_done_in;
   logic                        dut_run_valid_out;
   logic                        dut_run_rdy_in;
   logic                        dut_run_rden_out;
   logic                        dut_run_empty_in;
   logic                        dut_stall_rate_supported_in;
   logic                        dut_stall_rate_valid_out;
   logic [STALL_RATE_WIDTH-1:0] dut_stall_rate_out;

   modport master (
      output dut_rst_out, dut_run_valid_out, dut_run_rden_out, dut_stall_rate_valid_out,
             dut_stall_rate_out,
      input  dut_startup_done_in, dut_run_rdy_in, dut_run_empty_in, dut_stall_rate_supported_in
   );

   modport slave (
      input  dut_rst_out, dut_run_valid_out, dut_run_rden_out, dut_stall_rate_valid_out,
             dut_stall_rate_out,
      output dut_startup_done_in, dut_run_rdy_in, dut_run_empty_in, dut_stall_rate_supported_in
   );
endinterface

// File: rtl/test_run_watchdog.sv
// Clear/enable counter that flags expiry on the TIMEOUT_CYCLES-th enabled cycle after a clear.
module test_run_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/test_run_sequencer.sv
// Drives a generated test runner through reset, startup, config and a counted series of run
// calls; every output is registered.
module test_run_sequencer
   import test_run_sequencer_pkg::*;
#(
   parameter int unsigned RESET_CYCLES     = 10,
   parameter int unsigned TIMEOUT_CYCLES   = 1_000_000,
   parameter int unsigned STALL_RATE_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_in,
   input  logic [RUN_COUNT_WIDTH-1:0] run_count_in,
   input  logic [STALL_RATE_WIDTH-1:0] stall_rate_cfg_in,
   test_run_sequencer_if.master       dut_if,
   output logic                       busy_out,
   output logic                       done_out,
   output logic                       timeout_out,
   output logic [RUN_COUNT_WIDTH-1:0] runs_completed_out,
   output logic [LATENCY_WIDTH-1:0]   last_latency_out
);
   localparam int unsigned RstCntW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   state_t state_q, state_d;

   logic [RstCntW-1:0]          rst_cnt_q, rst_cnt_d;
   logic [RUN_COUNT_WIDTH-1:0]  count_q, count_d;
   logic [STALL_RATE_WIDTH-1:0] rate_q, rate_d;
   logic [RUN_COUNT_WIDTH-1:0]  runs_q, runs_d;
   logic [LATENCY_WIDTH-1:0]    lat_cnt_q, lat_cnt_d;
   logic [LATENCY_WIDTH-1:0]    last_lat_q, last_lat_d;

   logic dut_rst_q, dut_rst_d;
   logic run_valid_q, run_valid_d;
   logic rden_q, rden_d;
   logic stall_valid_q, stall_valid_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic timeout_q, timeout_d;

   logic start_acc, accept, wd_clear, wd_en, wd_expired;

   assign start_acc = start_in && (state_q inside {StIdle, StDone, StTimeout});
   assign accept    = (state_q == StIssue) && dut_if.dut_run_rdy_in;
   assign wd_en     = state_q inside {StWaitStartup, StIssue, StWaitResult};
   assign wd_clear  = (state_d inside {StWaitStartup, StIssue, StWaitResult}) &&
                      (state_d != state_q);

   test_run_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (wd_clear),
      .en_i     (wd_en),
      .expired_o(wd_expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // The awaited event wins over a watchdog expiry landing in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone, StTimeout: if (start_in) state_d = StDutReset;
         StDutReset: begin
            if (rst_cnt_q == RstCntW'(RESET_CYCLES - 1)) state_d = StWaitStartup;
         end
         StWaitStartup: begin
            if (dut_if.dut_startup_done_in) state_d = StConfig;
            else if (wd_expired)            state_d = StTimeout;
         end
         StConfig: state_d = (count_q == '0) ? StDone : StIssue;
         StIssue: begin
            if (dut_if.dut_run_rdy_in) state_d = StWaitResult;
            else if (wd_expired)       state_d = StTimeout;
         end
         StWaitResult: begin
            if (!dut_if.dut_run_empty_in) state_d = StPop;
            else if (wd_expired)          state_d = StTimeout;
         end
         StPop: state_d = (runs_q == count_q) ? StDone : StIssue;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      dut_rst_d     = state_d inside {StIdle, StDutReset, StTimeout};
      run_valid_d   = state_d == StIssue;
      rden_d        = state_d == StPop;
      stall_valid_d = (state_d == StConfig) && dut_if.dut_stall_rate_supported_in;
      busy_d        = !(state_d inside {StIdle, StDone, StTimeout});
      done_d        = (state_d == StDone) && (state_q != StDone);
      timeout_d     = state_d == StTimeout;
   end

   // Latency counter reads 0 in the accept cycle, so it loads 1 for the following one.
   always_comb begin
      rst_cnt_d  = (state_q == StDutReset) ? rst_cnt_q + RstCntW'(1) : '0;
      count_d    = count_q;
      rate_d     = rate_q;
      runs_d     = runs_q;
      lat_cnt_d  = lat_cnt_q;
      last_lat_d = last_lat_q;
      if (start_acc) begin
         count_d    = run_count_in;
         rate_d     = stall_rate_cfg_in;
         runs_d     = '0;
         last_lat_d = '0;
      end
      if (accept) begin
         lat_cnt_d = LATENCY_WIDTH'(1);
      end else if (state_q == StWaitResult) begin
         lat_cnt_d = sat_inc(lat_cnt_q);
      end
      if ((state_q == StWaitResult) && (state_d == StPop)) begin
         runs_d     = runs_q + RUN_COUNT_WIDTH'(1);
         last_lat_d = sat_inc(lat_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_cnt_q     <= '0;
         count_q       <= '0;
         rate_q        <= '0;
         runs_q        <= '0;
         lat_cnt_q     <= '0;
         last_lat_q    <= '0;
         dut_rst_q     <= 1'b1;
         run_valid_q   <= 1'b0;
         rden_q        <= 1'b0;
         stall_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         rst_cnt_q     <= rst_cnt_d;
         count_q       <= count_d;
         rate_q        <= rate_d;
         runs_q        <= runs_d;
         lat_cnt_q     <= lat_cnt_d;
         last_lat_q    <= last_lat_d;
         dut_rst_q     <= dut_rst_d;
         run_valid_q   <= run_valid_d;
         rden_q        <= rden_d;
         stall_valid_q <= stall_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
      end
   end

   assign dut_if.dut_rst_out              = dut_rst_q;
   assign dut_if.dut_run_valid_out        = run_valid_q;
   assign dut_if.dut_run_rden_out         = rden_q;
   assign dut_if.dut_stall_rate_valid_out = stall_valid_q;
   assign dut_if.dut_stall_rate_out       = rate_q;
   assign busy_out                        = busy_q;
   assign done_out                        = done_q;
   assign timeout_out                     = timeout_q;
   assign runs_completed_out              = runs_q;
   assign last_latency_out                = last_lat_q;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Directed bench for test_run_sequencer: the bench plays the runner cycle by cycle.
module tb_test_run_sequencer;
   localparam int unsigned RESET_CYCLES     = 4;
   localparam int unsigned TIMEOUT_CYCLES   = 50;
   localparam int unsigned STALL_RATE_WIDTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_in;
   logic [15:0] run_count_in;
   logic [7:0]  stall_rate_cfg_in;
   logic        busy_out, done_out, timeout_out;
   logic [15:0] runs_completed_out;
   logic [31:0] last_latency_out;

   int vecs = 0;
   int errs = 0;

   test_run_sequencer_if #(.STALL_RATE_WIDTH(STALL_RATE_WIDTH)) bus ();

   test_run_sequencer #(
      .RESET_CYCLES    (RESET_CYCLES),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
      .STALL_RATE_WIDTH(STALL_RATE_WIDTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start_in          (start_in),
      .run_count_in      (run_count_in),
      .stall_rate_cfg_in (stall_rate_cfg_in),
      .dut_if            (bus),
      .busy_out          (busy_out),
      .done_out          (done_out),
      .timeout_out       (timeout_out),
      .runs_completed_out(runs_completed_out),
      .last_latency_out  (last_latency_out)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_dut_rst"}, 32'(bus.dut_rst_out), 1);
      check({tag, "_busy"}, 32'(busy_out), 0);
      check({tag, "_done"}, 32'(done_out), 0);
      check({tag, "_timeout"}, 32'(timeout_out), 0);
      check({tag, "_valid"}, 32'(bus.dut_run_valid_out), 0);
      check({tag, "_rden"}, 32'(bus.dut_run_rden_out), 0);
      check({tag, "_stall_valid"}, 32'(bus.dut_stall_rate_valid_out), 0);
      check({tag, "_stall_rate"}, 32'(bus.dut_stall_rate_out), 0);
      check({tag, "_runs"}, 32'(runs_completed_out), 0);
      check({tag, "_latency"}, last_latency_out, 0);
   endtask

   // Start a campaign and step to the CONFIG cycle; a start pulse mid-startup must be ignored.
   task automatic bring_up(input logic [15:0] cnt, input logic sup, input logic [7:0] rate);
      int n;
      run_count_in      = cnt;
      stall_rate_cfg_in = rate;
      bus.dut_stall_rate_supported_in = sup;
      bus.dut_startup_done_in = 1'b0;
      start_in = 1'b1;
      tick;
      start_in = 1'b0;
      check("start_busy", 32'(busy_out), 1);
      check("start_timeout_clr", 32'(timeout_out), 0);
      check("start_runs_clr", 32'(runs_completed_out), 0);
      check("start_latency_clr", last_latency_out, 0);
      n = 0;
      while (bus.dut_rst_out === 1'b1 && n < 100) begin
         n++;
         tick;
      end
      check("dut_rst_len", 32'(n), RESET_CYCLES);
      start_in = 1'b1;
      tick;
      start_in = 1'b0;
      check("start_ignored_rst", 32'(bus.dut_rst_out), 0);
      check("start_ignored_busy", 32'(busy_out), 1);
      tick;
      bus.dut_startup_done_in = 1'b1;
      tick;
      check("cfg_valid", 32'(bus.dut_stall_rate_valid_out), 32'(sup));
      check("cfg_rate", 32'(bus.dut_stall_rate_out), 32'(rate));
      check("cfg_no_call", 32'(bus.dut_run_valid_out), 0);
      tick;
      check("cfg_pulse_end", 32'(bus.dut_stall_rate_valid_out), 0);
   endtask

   // Entered in an ISSUE cycle; empty falls d cycles after accept, so the pop lands at d+1.
   task automatic one_run(input int k, input int rdy_delay, input int d);
      bus.dut_run_empty_in = 1'b1;
      for (int i = 0; i < rdy_delay; i++) begin
         check("valid_hold", 32'(bus.dut_run_valid_out), 1);
         tick;
      end
      bus.dut_run_rdy_in = 1'b1;
      check("valid_accept", 32'(bus.dut_run_valid_out), 1);
      tick;
      bus.dut_run_rdy_in = 1'b0;
      check("valid_drop", 32'(bus.dut_run_valid_out), 0);
      for (int j = 1; j < d; j++) begin
         check("no_rden_while_empty", 32'(bus.dut_run_rden_out), 0);
         check("no_second_call", 32'(bus.dut_run_valid_out), 0);
         tick;
      end
      bus.dut_run_empty_in = 1'b0;
      tick;
      check("pop_rden", 32'(bus.dut_run_rden_out), 1);
      check("pop_runs", 32'(runs_completed_out), 32'(k));
      check("pop_latency", last_latency_out, 32'(d + 1));
      tick;
      bus.dut_run_empty_in = 1'b1;
      check("rden_one_cycle", 32'(bus.dut_run_rden_out), 0);
   endtask

   task automatic campaign(input logic [15:0] cnt, input logic sup, input logic [7:0] rate,
                           input int rdy_delay, input int d);
      int dones;
      bring_up(cnt, sup, rate);
      for (int k = 1; k <= int'(cnt); k++) one_run(k, rdy_delay, d);
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         if (done_out === 1'b1) dones++;
         if (i == 0) begin
            check("done_first_cycle", 32'(done_out), 1);
            check("done_busy", 32'(busy_out), 0);
            check("done_no_call", 32'(bus.dut_run_valid_out), 0);
            check("done_runs", 32'(runs_completed_out), 32'(cnt));
            check("done_latency", last_latency_out, (cnt == 0) ? 0 : 32'(d + 1));
         end
         check("done_dut_rst_low", 32'(bus.dut_rst_out), 0);
         tick;
      end
      check("done_pulse_count", 32'(dones), 1);
   endtask

   initial begin
      rst = 1'b0;
      start_in = 1'b0;
      run_count_in = '0;
      stall_rate_cfg_in = '0;
      bus.dut_startup_done_in = 1'b0;
      bus.dut_run_rdy_in = 1'b0;
      bus.dut_run_empty_in = 1'b1;
      bus.dut_stall_rate_supported_in = 1'b0;
      tick;
      tick;
      check_reset_values("por");
      rst = 1'b1;
      tick;
      check("idle_dut_rst", 32'(bus.dut_rst_out), 1);

      // Three runs, immediate rdy, pop 5 cycles after accept.
      campaign(16'd3, 1'b0, 8'h00, 0, 4);
      // rdy held off 4 cycles; stall rate 0x20 pushed in CONFIG.
      campaign(16'd1, 1'b1, 8'h20, 4, 2);
      // Unsupported stall config, different latency.
      campaign(16'd2, 1'b0, 8'h7f, 1, 1);
      // Zero runs: reset/startup only.
      campaign(16'd0, 1'b1, 8'h05, 0, 1);

      // Result never arrives: watchdog trips after TIMEOUT_CYCLES in WAIT_RESULT.
      bring_up(16'd1, 1'b0, 8'h00);
      bus.dut_run_rdy_in = 1'b1;
      tick;
      bus.dut_run_rdy_in = 1'b0;
      for (int i = 0; i < int'(TIMEOUT_CYCLES); i++) begin
         if (i == 0 || i == int'(TIMEOUT_CYCLES) - 1) begin
            check("tmo_pending", 32'(timeout_out), 0);
         end
         tick;
      end
      check("tmo_flag", 32'(timeout_out), 1);
      check("tmo_dut_rst", 32'(bus.dut_rst_out), 1);
      check("tmo_valid", 32'(bus.dut_run_valid_out), 0);
      check("tmo_busy", 32'(busy_out), 0);
      tick;
      check("tmo_sticky", 32'(timeout_out), 1);
      campaign(16'd1, 1'b1, 8'h11, 0, 3);

      // Async reset while waiting for a result.
      bring_up(16'd2, 1'b0, 8'h33);
      bus.dut_run_rdy_in = 1'b1;
      tick;
      bus.dut_run_rdy_in = 1'b0;
      tick;
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("async");
      bus.dut_run_empty_in = 1'b0;
      tick;
      check("async_no_rden", 32'(bus.dut_run_rden_out), 0);
      #2;
      rst = 1'b1;
      tick;
      check("async_stays_idle", 32'(busy_out), 0);
      check("async_idle_dut_rst", 32'(bus.dut_rst_out), 1);
      check("async_idle_no_rden", 32'(bus.dut_run_rden_out), 0);
      bus.dut_run_empty_in = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/test_run_sequencer.md
# test_run_sequencer

Synthesizable sequencer that drives a generated `_test_runner_main` instance in place of a simulation-only initial block. It pulses the runner's reset and waits for startup to finish. It optionally programs the stall rate, issues a configurable number of `run` calls and drains each result. It reports completion, per-run latency and watchdog timeouts, so on-board and emulation targets run the same test flow as simulation.

## Interface
- `RESET_CYCLES`, 10: cycles `dut_rst_out` is held high after a start.
- `TIMEOUT_CYCLES`, 1_000_000: watchdog limit per waiting phase. Must be ≥ 1.
- `STALL_RATE_WIDTH`, 8: width of the stall-rate value.
- `clk` in 1: single clock for the sequencer and the runner.
- `rst` in 1: asynchronous, active-low reset.
- `start_in` in 1: pulse. Begins a campaign; honoured only in IDLE, DONE or TIMEOUT.
- `run_count_in` in 16: runs per campaign, latched on start.
- `stall_rate_cfg_in` in `STALL_RATE_WIDTH`: stall rate, latched on start.
- `dut_rst_out` out 1: active-high reset to the runner.
- `dut_startup_done_in` in 1: runner's `rst_and_startup_done_out`.
- `dut_run_valid_out` out 1, `dut_run_rdy_in` in 1: call handshake.
- `dut_run_rden_out` out 1, `dut_run_empty_in` in 1: result FIFO pop.
- `dut_stall_rate_supported_in` in 1, `dut_stall_rate_valid_out` out 1, `dut_stall_rate_out` out `STALL_RATE_WIDTH`: stall config.
- `busy_out` out 1: high outside IDLE, DONE and TIMEOUT.
- `done_out` out 1: one-cycle pulse on entering DONE.
- `timeout_out` out 1: sticky, high in TIMEOUT.
- `runs_completed_out` out 16: results popped this campaign.
- `last_latency_out` out 32: cycles from call accept to result pop for the most recent run, saturating.

## Operation
- States: IDLE → DUT_RESET → WAIT_STARTUP → CONFIG → ISSUE ↔ WAIT_RESULT → POP → (ISSUE | DONE). Any watchdog expiry goes to TIMEOUT.
- IDLE/DONE/TIMEOUT + `start_in`:
  - latch `run_count_in` and `stall_rate_cfg_in`
  - clear `runs_completed_out`, `last_latency_out` and `timeout_out`
  - go to DUT_RESET.
- DUT_RESET: `dut_rst_out`=1 for exactly `RESET_CYCLES` cycles, then 0. Go to WAIT_STARTUP.
- WAIT_STARTUP: stay until `dut_startup_done_in`=1.
- CONFIG, one cycle:
  - If `dut_stall_rate_supported_in`=1, drive `dut_stall_rate_valid_out`=1 with the latched rate.
  - Else drive no pulse.
  - If the latched count is 0, go to DONE; else go to ISSUE.
- ISSUE: hold `dut_run_valid_out`=1 until the cycle where `dut_run_rdy_in`=1.
  - The transfer occurs in that cycle; valid drops the next cycle.
  - Start the latency counter, then go to WAIT_RESULT.
- WAIT_RESULT: stay while `dut_run_empty_in`=1. When it goes low, go to POP.
- POP: `dut_run_rden_out`=1 for exactly one cycle.
  - Increment `runs_completed_out`.
  - Latch the latency value into `last_latency_out`.
  - If runs completed equals the latched count, go to DONE; else go to ISSUE.
- Only one call is outstanding at a time. `rden` is never asserted while `empty`=1.
- Watchdog:
  - Cleared on entry to WAIT_STARTUP, ISSUE and WAIT_RESULT.
  - Counts each cycle spent in those states.
  - Reaching `TIMEOUT_CYCLES` goes to TIMEOUT: `timeout_out`=1, `dut_rst_out`=1 (runner held in reset), `run_valid`=0.
- `start_in` while busy is ignored.
- Async reset mid-campaign:
  - Go to IDLE immediately.
  - All outputs return to reset values.
  - The runner is held in reset via `dut_rst_out`=1.

## Timing
- Reset values:
  - `dut_rst_out`=1
  - all other 1-bit outputs 0
  - `dut_stall_rate_out`=0
  - counters 0
- All outputs are registered; no combinational input-to-output path.
- `start_in` at cycle t: `dut_rst_out` stays 1 for cycles t+1 through t+`RESET_CYCLES`, and is 0 at t+`RESET_CYCLES`+1.
- Latency is counted from the accept cycle (latency 0) and latched in the POP cycle. The count saturates at 2^32−1.
- `done_out` is asserted in the first DONE cycle only.
- IDLE keeps `dut_rst_out`=1. DONE keeps it 0, leaving the runner idle and out of reset.

## Structure
- `test_run_sequencer_pkg` holds:
  - the `state_t` enum
  - `RUN_COUNT_WIDTH`=16
  - `LATENCY_WIDTH`=32
- Sub-module `test_run_watchdog`: a clear/enable/expire counter parameterised by `TIMEOUT_CYCLES`.
- The FSM, latches and latency counter live in `test_run_sequencer`.

## Test plan
- Count 3, rdy asserted immediately, result 5 cycles after each accept → three 1-cycle `rden` pulses, `runs_completed_out`=3, `last_latency_out`=5, one `done_out` pulse.
- `rdy` low for 4 cycles after valid rises → valid held for 5 cycles, exactly one transfer, no second call before the pop.
- `stall_rate_supported`=1 with cfg 0x20 → one-cycle valid carrying 0x20 in CONFIG. `stall_rate_supported`=0 → no pulse.
- Count 0 → reset and startup sequence runs, no valid, `done_out` pulses, `runs_completed_out`=0.
- `TIMEOUT_CYCLES`=50 and `empty` never falls → `timeout_out`=1 after 50 cycles in WAIT_RESULT, `dut_rst_out`=1. A subsequent `start_in` clears `timeout_out` and restarts the campaign.
- Async `rst` low during WAIT_RESULT → same-cycle IDLE, all outputs at reset values, `dut_rst_out`=1, no `rden` issued.
